// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter (reverse double-dabble: shift right, subtract 3).
// One conversion per accepted start; busy frames the conversion, done pulses with the result.
module bcd2bin_seq #(
   parameter int unsigned NDIGITS = 2,
   parameter int unsigned BIN_W   = 7
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [4*NDIGITS-1:0]   bcd_in,
   output logic                   busy,
   output logic                   done,
   output logic [BIN_W-1:0]       bin_out,
   output logic                   err,
   output logic                   ovf
);

   localparam int unsigned BCD_W = 4 * NDIGITS;
   localparam int unsigned CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CHECK  = 3'd1,
      SHIFT  = 3'd2,
      ADJUST = 3'd3,
      DONE   = 3'd4
   } state_t;

   state_t            state;
   logic [BCD_W-1:0]  bcd_r;
   logic [BIN_W-1:0]  bin_r;
   logic [CNT_W-1:0]  cnt;

   logic              bad_digit_c;
   logic [BCD_W-1:0]  adj_bcd_c;
   logic [BCD_W-1:0]  sh_bcd_c;
   logic [BIN_W-1:0]  sh_bin_c;

   // Per-digit validity check and the >=8 correction, plus the combined right shift
   always_comb begin
      bad_digit_c = 1'b0;
      adj_bcd_c   = bcd_r;
      for (int i = 0; i < int'(NDIGITS); i++) begin
         if (bcd_r[4*i +: 4] > 4'd9)
            bad_digit_c = 1'b1;
         if (bcd_r[4*i +: 4] >= 4'd8)
            adj_bcd_c[4*i +: 4] = bcd_r[4*i +: 4] - 4'd3;
      end
      {sh_bcd_c, sh_bin_c} = {bcd_r, bin_r} >> 1;
   end

   // Result outputs are only written on the edge that enters DONE
   always_ff @(posedge clk) begin
      if (!reset) begin
         state   <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
         ovf     <= 1'b0;
         bin_out <= '0;
         bcd_r   <= '0;
         bin_r   <= '0;
         cnt     <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  bcd_r <= bcd_in;
                  bin_r <= '0;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= CHECK;
               end
            end
            CHECK: begin
               if (bad_digit_c) begin
                  err     <= 1'b1;
                  ovf     <= 1'b0;
                  bin_out <= '0;
                  done    <= 1'b1;
                  state   <= DONE;
               end else begin
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               bcd_r <= sh_bcd_c;
               bin_r <= sh_bin_c;
               if (cnt == CNT_LAST) begin
                  bin_out <= sh_bin_c;
                  ovf     <= |sh_bcd_c;
                  err     <= 1'b0;
                  done    <= 1'b1;
                  state   <= DONE;
               end else begin
                  cnt   <= cnt + CNT_W'(1);
                  state <= ADJUST;
               end
            end
            ADJUST: begin
               bcd_r <= adj_bcd_c;
               state <= SHIFT;
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
